// File: rtl/program_loader_if.sv
// rtl/program_loader_if.sv - receive FIFO pop port and instruction memory write port of the program loader
interface program_loader_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int WR_ADDR_WIDTH = 10
);
    logic                     fifo_empty;
    logic [7:0]               fifo_rd_data;
    logic                     fifo_rd_en;
    logic [DATA_WIDTH-1:0]    mem_data;
    logic [WR_ADDR_WIDTH-1:0] mem_wr_addr;
    logic                     mem_w_en;

    modport master (
        input  fifo_empty,
        input  fifo_rd_data,
        output fifo_rd_en,
        output mem_data,
        output mem_wr_addr,
        output mem_w_en
    );

    modport slave (
        output fifo_empty,
        output fifo_rd_data,
        input  fifo_rd_en,
        input  mem_data,
        input  mem_wr_addr,
        input  mem_w_en
    );
endinterface

// File: rtl/program_loader.sv
// rtl/program_loader.sv - parses a framed program image from a byte FIFO and writes it to instruction memory
module program_loader #(
    parameter int DATA_WIDTH    = 32,
    parameter int WR_ADDR_WIDTH = 10,
    parameter int MEM_DEPTH     = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    program_loader_if.master     bus,
    output logic                 cpu_hold,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);
    localparam int          WL_W      = $clog2(MEM_DEPTH / 4 + 1);
    localparam logic [15:0] MAX_WORDS = 16'(MEM_DEPTH / 4);
    localparam logic [1:0]  LAST_BYTE = 2'd3;

    typedef enum logic [2:0] {
        IDLE, HDR_HI, HDR_LO, PAYLOAD, WRITE, CHK, DONE, ERR
    } state_t;

    state_t                   state_q, state_d;
    logic [7:0]               count_hi_q, count_hi_d;
    logic [WL_W-1:0]          words_left_q, words_left_d;
    logic [1:0]               byte_idx_q, byte_idx_d;
    logic [DATA_WIDTH-1:0]    shift_q, shift_d;
    logic [7:0]               checksum_q, checksum_d;
    logic [WR_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    mem_data_q, mem_data_d;
    logic [WR_ADDR_WIDTH-1:0] mem_wr_addr_q, mem_wr_addr_d;
    logic                     done_q, done_d;

    logic                     pop;
    logic [15:0]              count;
    logic [DATA_WIDTH-1:0]    shift_next;

    // State and datapath registers; a reset mid-frame simply abandons the load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            count_hi_q    <= '0;
            words_left_q  <= '0;
            byte_idx_q    <= '0;
            shift_q       <= '0;
            checksum_q    <= '0;
            addr_q        <= '0;
            mem_data_q    <= '0;
            mem_wr_addr_q <= '0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_hi_q    <= count_hi_d;
            words_left_q  <= words_left_d;
            byte_idx_q    <= byte_idx_d;
            shift_q       <= shift_d;
            checksum_q    <= checksum_d;
            addr_q        <= addr_d;
            mem_data_q    <= mem_data_d;
            mem_wr_addr_q <= mem_wr_addr_d;
            done_q        <= done_d;
        end
    end

    // Frame parser: pops only in byte-consuming states, stalls while the FIFO is empty
    always_comb begin
        state_d       = state_q;
        count_hi_d    = count_hi_q;
        words_left_d  = words_left_q;
        byte_idx_d    = byte_idx_q;
        shift_d       = shift_q;
        checksum_d    = checksum_q;
        addr_d        = addr_q;
        mem_data_d    = mem_data_q;
        mem_wr_addr_d = mem_wr_addr_q;
        done_d        = 1'b0;

        pop        = ((state_q == HDR_HI) || (state_q == HDR_LO) ||
                      (state_q == PAYLOAD) || (state_q == CHK)) && !bus.fifo_empty;
        count      = {count_hi_q, bus.fifo_rd_data};
        shift_next = {shift_q[DATA_WIDTH-9:0], bus.fifo_rd_data};

        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d    = HDR_HI;
                    checksum_d = '0;
                    byte_idx_d = '0;
                    addr_d     = '0;
                end
            end
            HDR_HI: begin
                if (pop) begin
                    count_hi_d = bus.fifo_rd_data;
                    state_d    = HDR_LO;
                end
            end
            HDR_LO: begin
                if (pop) begin
                    if ((count == 16'd0) || (count > MAX_WORDS)) begin
                        state_d = ERR;
                    end else begin
                        words_left_d = count[WL_W-1:0];
                        state_d      = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (pop) begin
                    shift_d    = shift_next;
                    checksum_d = checksum_q + bus.fifo_rd_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == LAST_BYTE) begin
                        // Output registers are loaded here so they present the word during WRITE
                        mem_data_d    = shift_next;
                        mem_wr_addr_d = addr_q;
                        state_d       = WRITE;
                    end
                end
            end
            WRITE: begin
                addr_d       = addr_q + WR_ADDR_WIDTH'(4);
                words_left_d = words_left_q - WL_W'(1);
                byte_idx_d   = '0;
                state_d      = (words_left_q == WL_W'(1)) ? CHK : PAYLOAD;
            end
            CHK: begin
                if (pop) begin
                    if (bus.fifo_rd_data == checksum_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ERR;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.fifo_rd_en  = pop;
    assign bus.mem_data    = mem_data_q;
    assign bus.mem_wr_addr = mem_wr_addr_q;
    assign bus.mem_w_en    = (state_q == WRITE);
    assign busy            = (state_q != IDLE) && (state_q != DONE) && (state_q != ERR);
    assign cpu_hold        = busy;
    assign done            = done_q;
    assign error           = (state_q == ERR);
endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - directed self-checking bench for program_loader
module tb_program_loader;
    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic cpu_hold, busy, done, error;

    always #5 clk = ~clk;

    program_loader_if #(.DATA_WIDTH(32), .WR_ADDR_WIDTH(10)) bus ();

    program_loader #(.DATA_WIDTH(32), .WR_ADDR_WIDTH(10), .MEM_DEPTH(1024)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bus      (bus.master),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    logic [7:0]  q[$];
    logic [9:0]  wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          pops, cyc, done_cnt, stall_at, stall_left, stall_pops;
    logic        saw_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_fifo();
        bus.fifo_empty   = (q.size() == 0) || (stall_left > 0);
        bus.fifo_rd_data = (q.size() != 0) ? q[0] : 8'h00;
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        pops       = 0;
        done_cnt   = 0;
        stall_pops = 0;
        saw_err    = 1'b0;
    endtask

    // One clock: sample DUT at the falling edge, then model the FIFO pop after the rising edge
    task automatic step();
        logic pend;
        @(negedge clk);
        pend = bus.fifo_rd_en;
        if (pend && stall_left > 0) stall_pops++;
        if (bus.mem_w_en) begin
            wr_addr.push_back(bus.mem_wr_addr);
            wr_data.push_back(bus.mem_data);
            wr_cyc.push_back(cyc);
        end
        if (done) done_cnt++;
        if (error) saw_err = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        if (stall_left > 0) stall_left--;
        if (pend && q.size() != 0) begin
            void'(q.pop_front());
            pops++;
            if (pops == stall_at) stall_left = 10;
        end
        drive_fifo();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic run_to_end(input string tag);
        int i = 0;
        while (!(done_cnt > 0 || saw_err) && i < 400) begin
            step();
            i++;
        end
        check({tag, "_finished"}, (done_cnt > 0 || saw_err), 1'b1);
        step();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},  busy, 1'b0);
        check({tag, "_hold"},  cpu_hold, 1'b0);
        check({tag, "_done"},  done, 1'b0);
        check({tag, "_err"},   error, 1'b0);
        check({tag, "_rden"},  bus.fifo_rd_en, 1'b0);
        check({tag, "_wen"},   bus.mem_w_en, 1'b0);
        check({tag, "_data"},  bus.mem_data, 32'h0);
        check({tag, "_addr"},  bus.mem_wr_addr, 10'h0);
    endtask

    initial begin
        int i;
        rst_n = 1'b0;
        start = 1'b0;
        cyc = 0;
        stall_at = 0;
        stall_left = 0;
        clear_log();
        drive_fifo();
        step();
        step();
        check_idle_outputs("reset");
        rst_n = 1'b1;
        step();

        // Basic one-word load: payload sum DE+AD+BE+EF = 0x338 -> 0x38
        q = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h38};
        drive_fifo();
        pulse_start();
        clear_log();
        run_to_end("basic");
        check("basic_nwr", wr_addr.size(), 1);
        check("basic_addr", wr_addr[0], 10'd0);
        check("basic_data", wr_data[0], 32'hDEADBEEF);
        check("basic_done", done_cnt, 1);
        check("basic_err", error, 1'b0);
        check("basic_hold", cpu_hold, 1'b0);
        check("basic_busy", busy, 1'b0);
        check("basic_pops", pops, 7);

        // Three words with a start pulse injected mid-load; checksum 0xB2
        q = '{8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00, 8'h93,
              8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hB2};
        drive_fifo();
        pulse_start();
        clear_log();
        i = 0;
        while (wr_addr.size() == 0 && i < 100) begin
            step();
            i++;
        end
        pulse_start();
        run_to_end("multi");
        check("multi_nwr", wr_addr.size(), 3);
        if (wr_addr.size() == 3) begin
            check("multi_addr0", wr_addr[0], 10'd0);
            check("multi_addr1", wr_addr[1], 10'd4);
            check("multi_addr2", wr_addr[2], 10'd8);
            check("multi_data0", wr_data[0], 32'h00000013);
            check("multi_data1", wr_data[1], 32'h00100093);
            check("multi_data2", wr_data[2], 32'hFFFFFFFF);
            check("multi_gap1", wr_cyc[1] - wr_cyc[0], 5);
            check("multi_gap2", wr_cyc[2] - wr_cyc[1], 5);
        end
        check("multi_done", done_cnt, 1);
        check("multi_err", error, 1'b0);
        check("multi_pops", pops, 15);

        // Header count of zero
        q = '{8'h00, 8'h00, 8'h11, 8'h22};
        drive_fifo();
        pulse_start();
        clear_log();
        run_to_end("hdr0");
        check("hdr0_err", error, 1'b1);
        check("hdr0_pops", pops, 2);
        check("hdr0_nwr", wr_addr.size(), 0);
        step();
        step();
        check("hdr0_sticky", error, 1'b1);
        check("hdr0_hold", cpu_hold, 1'b0);

        // Header count of 257 exceeds the 256-word memory
        q = '{8'h01, 8'h01, 8'h11, 8'h22};
        drive_fifo();
        pulse_start();
        check("hdr257_err_cleared", error, 1'b0);
        clear_log();
        run_to_end("hdr257");
        check("hdr257_err", error, 1'b1);
        check("hdr257_pops", pops, 2);
        check("hdr257_nwr", wr_addr.size(), 0);
        step();
        check("hdr257_sticky", error, 1'b1);

        // Wrong checksum byte (correct would be 0x38)
        q = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h3C};
        drive_fifo();
        pulse_start();
        clear_log();
        run_to_end("chk");
        check("chk_nwr", wr_addr.size(), 1);
        check("chk_addr", wr_addr[0], 10'd0);
        check("chk_err", error, 1'b1);
        check("chk_done", done_cnt, 0);

        // Ten empty cycles after the second payload byte (fourth pop overall)
        q = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h38};
        stall_at = 4;
        drive_fifo();
        pulse_start();
        clear_log();
        run_to_end("stall");
        stall_at = 0;
        check("stall_pops_while_empty", stall_pops, 0);
        check("stall_data", wr_data[0], 32'hDEADBEEF);
        check("stall_done", done_cnt, 1);
        check("stall_total_pops", pops, 7);

        // Asynchronous reset in the middle of word 2, then a fresh frame
        q = '{8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00, 8'h93,
              8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hB2};
        drive_fifo();
        pulse_start();
        clear_log();
        i = 0;
        while (wr_addr.size() == 0 && i < 100) begin
            step();
            i++;
        end
        step();
        step();
        check("rst_pre_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async_rst");
        q.delete();
        drive_fifo();
        step();
        rst_n = 1'b1;
        step();
        q = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h14};
        drive_fifo();
        pulse_start();
        clear_log();
        run_to_end("restart");
        check("restart_nwr", wr_addr.size(), 1);
        check("restart_addr", wr_addr[0], 10'd0);
        check("restart_data", wr_data[0], 32'h12345678);
        check("restart_done", done_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
